// File: rtl/cgra_axil_master.sv
`timescale 1ns/1ps
// Single-outstanding AXI4-Lite initiator: command/response stream in, AXI4-Lite out.
// Optional watchdog enabled by defining CGRA_AXIL_TIMEOUT_EN.
module cgra_axil_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  timeout_flag,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("cgra_axil_master: DATA_WIDTH must be 32");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cgra_axil_master: TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_busy;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [1:0]            r_rsp_resp;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic                  r_awvalid;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_rready;

    logic w_cmd_fire;
    logic w_aw_done;
    logic w_w_done;

    assign w_cmd_fire = cmd_valid & r_cmd_ready;
    // A channel counts as done once its valid has dropped or is handshaking now.
    assign w_aw_done  = ~r_awvalid | m_axi_awready;
    assign w_w_done   = ~r_wvalid | m_axi_wready;

`ifdef CGRA_AXIL_TIMEOUT_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wdog;
    logic        r_rsp_timeout;
    logic        r_timeout_flag;
    logic        w_wdog_active;
    logic        w_wdog_expired;

    assign w_wdog_active  = (r_state == WR_AW_W) || (r_state == WR_B) ||
                            (r_state == RD_AR)   || (r_state == RD_R);
    assign w_wdog_expired = w_wdog_active && (r_wdog == WDOG_LIMIT);
    assign rsp_timeout    = r_rsp_timeout;
    assign timeout_flag   = r_timeout_flag;
`else
    assign rsp_timeout    = 1'b0;
    assign timeout_flag   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= 4'h0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
`ifdef CGRA_AXIL_TIMEOUT_EN
            r_wdog         <= 16'd0;
            r_rsp_timeout  <= 1'b0;
            r_timeout_flag <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_AW_W;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= RD_AR;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                WR_AW_W: begin
                    if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_axi_bvalid && r_bready) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= m_axi_bresp;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RSP;
                    end
                end
                RD_AR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_R;
                    end
                end
                RD_R: begin
                    if (m_axi_rvalid && r_rready) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= m_axi_rresp;
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
`ifdef CGRA_AXIL_TIMEOUT_EN
            if (w_cmd_fire) begin
                r_wdog        <= 16'd0;
                r_rsp_timeout <= 1'b0;
            end else if (w_wdog_active) begin
                r_wdog <= r_wdog + 16'd1;
            end
            // Expiry overrides whatever the bus did this cycle and abandons the transaction.
            if (w_wdog_expired) begin
                r_awvalid      <= 1'b0;
                r_wvalid       <= 1'b0;
                r_bready       <= 1'b0;
                r_arvalid      <= 1'b0;
                r_rready       <= 1'b0;
                r_rsp_resp     <= 2'b10;
                r_rsp_rdata    <= '0;
                r_rsp_valid    <= 1'b1;
                r_rsp_timeout  <= 1'b1;
                r_timeout_flag <= 1'b1;
                r_state        <= RSP;
            end
`endif
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_cgra_axil_master.sv
`timescale 1ns/1ps
// Bench for cgra_axil_master: scripted AXI4-Lite slave with wait states, memory model and latency arithmetic.
module tb_cgra_axil_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        busy;
    logic        timeout_flag;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    int n_cmp = 0;
    int n_fail = 0;
    logic        tflag_exp = 1'b0;
    logic [31:0] smem [8];
    logic [31:0] mmem [8];

    always #5 clk = ~clk;

    cgra_axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy), .timeout_flag(timeout_flag),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic slave_idle();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        rsp_ready = 1'b0;
    endtask

    // One command end to end; the slave waits *_lat cycles of valid before ready,
    // and raises bvalid/rvalid b_lat/r_lat cycles after the cycle following the last handshake.
    task automatic do_txn(input string name, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int aw_lat, input int w_lat, input int b_lat,
                          input int ar_lat, input int r_lat, input logic [1:0] resp,
                          input int hold, input bit exp_to);
        int guard, aw_high, w_high, ar_high, rsp_seen, rsp_cyc, rdy_first;
        int aw_hs, w_hs, ar_hs, viol, hold_viol, exp_rsp_cyc, exp_rdy;
        int exp_aw_high, exp_w_high, exp_ar_high;
        bit aw_done, w_done, b_done, ar_done, r_done, fin;
        logic [31:0] s_addr, s_data, got_rdata, exp_rdata;
        logic [3:0]  s_strb;
        logic [1:0]  got_resp, exp_resp;
        logic        got_to, exp_to_v;
        aw_high = 0; w_high = 0; ar_high = 0; rsp_seen = 0; rsp_cyc = -1; rdy_first = -1;
        aw_hs = 0; w_hs = 0; ar_hs = 0; viol = 0; hold_viol = 0;
        aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; r_done = 0; fin = 0;
        s_addr = '0; s_data = '0; s_strb = '0; got_rdata = '0; got_resp = '0; got_to = 1'b0;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s cmd_accept: cmd_ready=%b, required 1", name, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            slave_idle();
            if (cmd_ready !== 1'b0 || busy !== 1'b1) viol++;
            if (wr) begin
                if (cyc == 1 && (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1)) viol++;
                if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) viol++;
                if (m_axi_awvalid === 1'b1) begin
                    if (aw_done || m_axi_awaddr !== addr) viol++;
                    m_axi_awready = (aw_high >= aw_lat);
                    aw_high++;
                    if (m_axi_awready) begin aw_done = 1; aw_hs = cyc; s_addr = m_axi_awaddr; end
                end
                if (m_axi_wvalid === 1'b1) begin
                    if (w_done || m_axi_wdata !== data || m_axi_wstrb !== strb) viol++;
                    m_axi_wready = (w_high >= w_lat);
                    w_high++;
                    if (m_axi_wready) begin w_done = 1; w_hs = cyc; s_data = m_axi_wdata; s_strb = m_axi_wstrb; end
                end
                if (m_axi_bready === 1'b1 && rdy_first < 0) rdy_first = cyc;
                if (aw_done && w_done && !b_done && cyc >= imax(aw_hs, w_hs) + 1 + b_lat) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp = resp;
                    if (m_axi_bready === 1'b1) begin
                        b_done = 1;
                        smem[s_addr[4:2]] = merge(smem[s_addr[4:2]], s_data, s_strb);
                    end
                end
            end else begin
                if (cyc == 1 && m_axi_arvalid !== 1'b1) viol++;
                if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || m_axi_bready !== 1'b0) viol++;
                if (m_axi_arvalid === 1'b1) begin
                    if (ar_done || m_axi_araddr !== addr) viol++;
                    m_axi_arready = (ar_high >= ar_lat);
                    ar_high++;
                    if (m_axi_arready) begin ar_done = 1; ar_hs = cyc; s_addr = m_axi_araddr; end
                end
                if (m_axi_rready === 1'b1 && rdy_first < 0) rdy_first = cyc;
                if (ar_done && !r_done && cyc >= ar_hs + 1 + r_lat) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata = smem[s_addr[4:2]];
                    m_axi_rresp = resp;
                    if (m_axi_rready === 1'b1) r_done = 1;
                end
            end
            if (rsp_valid === 1'b1) begin
                if (rsp_cyc < 0) begin
                    rsp_cyc = cyc; got_rdata = rsp_rdata; got_resp = rsp_resp; got_to = rsp_timeout;
                end else if (rsp_rdata !== got_rdata || rsp_resp !== got_resp || rsp_timeout !== got_to) begin
                    hold_viol++;
                end
                rsp_ready = (rsp_seen >= hold);
                rsp_seen++;
                if (rsp_ready) fin = 1;
            end
        end
        n_cmp++;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s rsp_handshake: no response within budget, required one", name);
            slave_idle();
            return;
        end
        @(negedge clk);
        slave_idle();

        if (exp_to) begin
            exp_resp = 2'b10; exp_rdata = '0; exp_to_v = 1'b1; exp_rsp_cyc = TO + 1; exp_rdy = -1;
            exp_aw_high = wr ? ((aw_lat + 1 < TO) ? aw_lat + 1 : TO) : 0;
            exp_w_high  = wr ? ((w_lat + 1 < TO) ? w_lat + 1 : TO) : 0;
            exp_ar_high = wr ? 0 : ((ar_lat + 1 < TO) ? ar_lat + 1 : TO);
            tflag_exp = 1'b1;
        end else begin
            exp_resp = resp; exp_to_v = 1'b0;
            exp_rdata = wr ? 32'h0 : mmem[addr[4:2]];
            exp_rsp_cyc = wr ? 3 + imax(aw_lat, w_lat) + b_lat : 3 + ar_lat + r_lat;
            exp_rdy = wr ? 2 + imax(aw_lat, w_lat) : 2 + ar_lat;
            exp_aw_high = wr ? aw_lat + 1 : 0;
            exp_w_high  = wr ? w_lat + 1 : 0;
            exp_ar_high = wr ? 0 : ar_lat + 1;
            if (wr) mmem[addr[4:2]] = merge(mmem[addr[4:2]], data, strb);
        end

        n_cmp++;
        if (got_rdata !== exp_rdata) begin n_fail++; $display("FAIL %s rsp_rdata: got %h, required %h", name, got_rdata, exp_rdata); end
        n_cmp++;
        if (got_resp !== exp_resp) begin n_fail++; $display("FAIL %s rsp_resp: got %b, required %b", name, got_resp, exp_resp); end
        n_cmp++;
        if (got_to !== exp_to_v) begin n_fail++; $display("FAIL %s rsp_timeout: got %b, required %b", name, got_to, exp_to_v); end
        n_cmp++;
        if (rsp_cyc != exp_rsp_cyc) begin n_fail++; $display("FAIL %s rsp_cycle: got %0d, required %0d", name, rsp_cyc, exp_rsp_cyc); end
        if (!exp_to) begin
            n_cmp++;
            if (rdy_first != exp_rdy) begin n_fail++; $display("FAIL %s b/r_ready_first_cycle: got %0d, required %0d", name, rdy_first, exp_rdy); end
        end
        n_cmp++;
        if (aw_high != exp_aw_high || w_high != exp_w_high || ar_high != exp_ar_high) begin
            n_fail++;
            $display("FAIL %s valid_high_cycles: aw/w/ar got %0d/%0d/%0d, required %0d/%0d/%0d",
                     name, aw_high, w_high, ar_high, exp_aw_high, exp_w_high, exp_ar_high);
        end
        n_cmp++;
        if (viol != 0) begin n_fail++; $display("FAIL %s channel_protocol: %0d bad cycles, required 0", name, viol); end
        n_cmp++;
        if (hold_viol != 0) begin n_fail++; $display("FAIL %s rsp_stable: %0d changes, required 0", name, hold_viol); end
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_rsp: cmd_ready/busy/rsp_valid got %b%b%b, required 100", name, cmd_ready, busy, rsp_valid);
        end
        n_cmp++;
        if (timeout_flag !== tflag_exp) begin n_fail++; $display("FAIL %s timeout_flag: got %b, required %b", name, timeout_flag, tflag_exp); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        slave_idle();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
             rsp_valid, cmd_ready, busy, rsp_timeout, timeout_flag} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_controls: got %b, required all 0", {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                     m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready, busy, rsp_timeout, timeout_flag});
        end
        n_cmp++;
        if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr, rsp_rdata, rsp_resp} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: awaddr %h wdata %h wstrb %h araddr %h rdata %h resp %b, required all 0",
                     m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr, rsp_rdata, rsp_resp);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_write_read();
        do_txn("wr_0x08", 1'b1, 32'h08, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0);
        do_txn("rd_0x08", 1'b0, 32'h08, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0);
    endtask

    task automatic test_skewed_write();
        do_txn("skew_aw", 1'b1, 32'h0C, 32'hA5A5_0F0F, 4'b0101, 3, 0, 0, 0, 0, 2'b00, 0, 1'b0);
        do_txn("skew_w",  1'b1, 32'h14, 32'h0BAD_CAFE, 4'b1010, 0, 2, 1, 0, 0, 2'b00, 0, 1'b0);
    endtask

    task automatic test_error_passthrough();
        do_txn("err_wr", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b11, 0, 1'b0);
        do_txn("err_rd", 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 0, 1'b0);
    endtask

    task automatic test_rsp_backpressure();
        do_txn("bp_wr", 1'b1, 32'h18, 32'h5555_AAAA, 4'b0011, 1, 1, 0, 0, 0, 2'b00, 5, 1'b0);
        do_txn("bp_rd", 1'b0, 32'h18, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b00, 5, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            bit          wr;
            logic [31:0] a;
            wr = ($urandom_range(0, 1) == 1);
            a  = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            do_txn("random", wr, a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 3), 1'b0);
        end
    endtask

`ifdef CGRA_AXIL_TIMEOUT_EN
    task automatic test_timeout();
        do_txn("to_aw",   1'b1, 32'h04, 32'h1111_2222, 4'hF, 1000, 0, 0, 0, 0, 2'b00, 0, 1'b1);
        do_txn("to_after", 1'b0, 32'h08, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 1, 1'b0);
        do_txn("to_r",    1'b0, 32'h1C, 32'h0, 4'h0, 0, 0, 0, 0, 1000, 2'b00, 0, 1'b1);
        do_txn("to_after2", 1'b1, 32'h1C, 32'h7777_8888, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0);
    endtask
`endif

    task automatic test_reset_mid_read();
        int guard;
        int seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0C;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        m_axi_arready = 1'b1;
        n_cmp++;
        if (m_axi_arvalid !== 1'b1) begin n_fail++; $display("FAIL mid_reset arvalid: got %b, required 1", m_axi_arvalid); end
        @(negedge clk);
        m_axi_arready = 1'b0;
        n_cmp++;
        if (m_axi_rready !== 1'b1) begin n_fail++; $display("FAIL mid_reset rready: got %b, required 1", m_axi_rready); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset async_clear: arvalid/rready/rsp_valid/cmd_ready/busy got %b, required 00000",
                     {m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready, busy});
        end
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hFEED_F00D;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || m_axi_rready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset release: cmd_ready/rsp_valid/rready/busy got %b%b%b%b, required 1000",
                     cmd_ready, rsp_valid, m_axi_rready, busy);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_fail++; $display("FAIL mid_reset no_response: rsp_valid high %0d cycles, required 0", seen); end
        slave_idle();
        tflag_exp = 1'b0;
        n_cmp++;
        if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL mid_reset timeout_flag: got %b, required 0", timeout_flag); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = $urandom;
            smem[i] = v;
            mmem[i] = v;
        end
        test_reset();
        test_write_read();
        test_skewed_write();
        test_error_passthrough();
        test_rsp_backpressure();
        test_random();
`ifdef CGRA_AXIL_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_read();
        do_txn("post_reset", 1'b0, 32'h08, 32'h0, 4'h0, 1, 0, 0, 0, 2, 2'b00, 0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cgra_axil_master.md
# cgra_axil_master

Single-outstanding AXI4-Lite initiator. It turns a simple command/response stream into AXI4-Lite write and read transactions aimed at CGRA control/status register slaves. It sits between the on-chip host sequencer (boot loader / job scheduler) and the CSR interconnect, and is the peer of the CGRA CSR slave. Responses return in order, one at a time, with an optional watchdog timeout.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI and command address width
- DATA_WIDTH, 32, data width; must be 32
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; legal range 2..65535; used only with CGRA_AXIL_TIMEOUT_EN

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address, passed through unmodified
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  AXI response code (BRESP or RRESP)
- rsp_timeout  out  1  response was generated by the watchdog
- busy  out  1  high in every state except IDLE
- timeout_flag  out  1  sticky; cleared only by reset
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master, with ADDR_WIDTH / DATA_WIDTH / 4 / 2 bit widths
- m_axi_awprot and m_axi_arprot are not provided

## Operation
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_*.
  - Next state is WR_AW_W if cmd_write, else RD_AR.
- WR_AW_W:
  - awvalid and wvalid rise together on entry.
  - Each drops independently on its own handshake.
  - Address and data stay stable until their handshake.
  - When both handshakes are done (same cycle or different cycles), go to WR_B.
- WR_B:
  - bready = 1.
  - On bvalid & bready: capture bresp into rsp_resp, set rsp_rdata = 0, go to RSP.
- RD_AR:
  - arvalid = 1 until arready.
  - Then go to RD_R.
- RD_R:
  - rready = 1.
  - On rvalid & rready: capture rdata and rresp, go to RSP.
- RSP:
  - rsp_valid = 1.
  - Response fields are held stable until rsp_ready.
  - Then go to IDLE.
- cmd_ready is 0 in every state except IDLE, so only one transaction is ever outstanding.
- Every AXI valid/ready output is registered. Every cmd/rsp output is registered.
- A response code other than 00 (SLVERR, DECERR) is passed through unchanged. It does not affect the FSM.

## Timing
- Reset (async assert, sync deassert):
  - state = IDLE.
  - All m_axi valid/ready = 0; all m_axi address/data/strb = 0.
  - cmd_ready = 0 during reset, 1 on the first clock edge after deassertion.
  - rsp_valid = 0, rsp_rdata = 0, rsp_resp = 00, rsp_timeout = 0.
  - busy = 0, timeout_flag = 0, watchdog = 0.
- Reset asserted mid-transaction: abandon immediately and take reset values. No response is emitted.
- Cycle numbering: command handshake at cycle 0.
  - awvalid/wvalid (or arvalid) are high in cycle 1.
  - bready/rready go high in the cycle after the last address/data handshake.
  - rsp_valid goes high in the cycle after the B/R handshake.
- Minimum write latency, against a zero-wait slave with bvalid one cycle after the handshake: rsp_valid in cycle 3. Reads are the same.
- Back-to-back commands: a new cmd_ready occurs in the cycle after the rsp handshake. Minimum command spacing is 4 cycles.
- The block ignores bvalid/rvalid while it is not in WR_B/RD_R.

## Configuration
- Macro CGRA_AXIL_TIMEOUT_EN defined:
  - A 16-bit watchdog clears on entry to WR_AW_W or RD_AR.
  - It increments in WR_AW_W, WR_B, RD_AR and RD_R.
  - When it reaches TIMEOUT_CYCLES-1:
    - next cycle, all m_axi valid/ready = 0;
    - rsp_resp = 10, rsp_rdata = 0, rsp_timeout = 1, timeout_flag = 1;
    - state goes to RSP.
  - After a timeout, software must reset the interconnect before issuing new traffic.
- Macro undefined:
  - No watchdog; the block waits forever.
  - rsp_timeout and timeout_flag are tied to 0.

## Test plan
- Write then read against the CSR slave: write addr 0x08, data 0x1234_5678, strb 0xF; then read 0x08 → write rsp_resp 00, then read rsp_rdata 0x1234_5678 with rsp_resp 00.
- Skewed write channels: slave asserts wready in cycle 1 and awready in cycle 4 → wvalid low from cycle 2, awaddr stable through cycle 4, bready first high in cycle 5.
- Error pass-through: slave returns RRESP 10 with rdata 0xDEADBEEF → rsp_resp 10, rsp_rdata 0xDEADBEEF, rsp_timeout 0.
- Response backpressure: hold rsp_ready low for 5 cycles after rsp_valid → rsp fields stable, cmd_ready 0 and busy 1 throughout; IDLE on the cycle after rsp_ready.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): slave never asserts awready → awvalid drops after 16 cycles high; rsp_resp 10, rsp_timeout 1, timeout_flag stays 1 across later commands.
- Reset mid-read: pull rst_n low while in RD_R → arvalid/rready/rsp_valid go to 0 asynchronously; after release, cmd_ready is 1 and no response is emitted.
